// File: rtl/axi_mailbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_mailbox_pkg
// Description : Shared types and constants for the AXI4-lite mailbox master.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_mailbox_pkg;

    localparam int          NWORDS          = 4;
    localparam int          STATUS_DONE_BIT = 0;
    localparam logic [1:0]  LAST_IDX        = 2'(NWORDS - 1);
    localparam logic [2:0]  AXI_PROT        = 3'b000;
    localparam logic [3:0]  AXI_STRB        = 4'hF;

    typedef enum logic [2:0] {
        MB_IDLE = 3'd0,
        MB_WR   = 3'd1,
        MB_PR   = 3'd2,
        MB_PG   = 3'd3,
        MB_RA   = 3'd4,
        MB_DN   = 3'd5,
        MB_TO   = 3'd6
    } mb_state_t;

    typedef enum logic [2:0] {
        ENG_IDLE = 3'd0,
        ENG_W    = 3'd1,
        ENG_B    = 3'd2,
        ENG_AR   = 3'd3,
        ENG_R    = 3'd4
    } eng_state_t;

    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [1:0]  idx,
                                              input logic [31:0] stride);
        return base + ({30'd0, idx} * stride);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_mailbox_master_engine.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_single_master
// Description : Single-beat AXI4-lite read/write engine, one transaction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_single_master
    import axi_mailbox_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,
    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,
    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready,
    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,
    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,
    input  logic [31:0] mem_axi_rdata
);

    eng_state_t r_state;
    logic       w_aw_hs;
    logic       w_w_hs;
    logic       w_accept;

    assign w_aw_hs = mem_axi_awvalid && mem_axi_awready;
    assign w_w_hs  = mem_axi_wvalid && mem_axi_wready;

    // ack is the response handshake itself, so the caller can chain the next request in the same cycle
    assign ack      = ((r_state == ENG_B) && mem_axi_bready && mem_axi_bvalid) ||
                      ((r_state == ENG_R) && mem_axi_rready && mem_axi_rvalid);
    assign rdata    = mem_axi_rdata;
    assign w_accept = req && ((r_state == ENG_IDLE) || ack);

    assign mem_axi_awprot = AXI_PROT;
    assign mem_axi_arprot = AXI_PROT;
    assign mem_axi_wstrb  = AXI_STRB;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state         <= ENG_IDLE;
            mem_axi_awvalid <= 1'b0;
            mem_axi_wvalid  <= 1'b0;
            mem_axi_bready  <= 1'b0;
            mem_axi_arvalid <= 1'b0;
            mem_axi_rready  <= 1'b0;
            mem_axi_awaddr  <= 32'd0;
            mem_axi_wdata   <= 32'd0;
            mem_axi_araddr  <= 32'd0;
        end else begin
            case (r_state)
                ENG_W: begin
                    if (w_aw_hs) mem_axi_awvalid <= 1'b0;
                    if (w_w_hs)  mem_axi_wvalid  <= 1'b0;
                    if ((!mem_axi_awvalid || w_aw_hs) && (!mem_axi_wvalid || w_w_hs)) begin
                        mem_axi_bready <= 1'b1;
                        r_state        <= ENG_B;
                    end
                end
                ENG_B: begin
                    if (mem_axi_bvalid) begin
                        mem_axi_bready <= 1'b0;
                        r_state        <= ENG_IDLE;
                    end
                end
                ENG_AR: begin
                    if (mem_axi_arready) begin
                        mem_axi_arvalid <= 1'b0;
                        mem_axi_rready  <= 1'b1;
                        r_state         <= ENG_R;
                    end
                end
                ENG_R: begin
                    if (mem_axi_rvalid) begin
                        mem_axi_rready <= 1'b0;
                        r_state        <= ENG_IDLE;
                    end
                end
                default: r_state <= ENG_IDLE;
            endcase

            // A new request overrides the return to idle above
            if (w_accept) begin
                if (we) begin
                    mem_axi_awvalid <= 1'b1;
                    mem_axi_wvalid  <= 1'b1;
                    mem_axi_awaddr  <= addr;
                    mem_axi_wdata   <= wdata;
                    r_state         <= ENG_W;
                end else begin
                    mem_axi_arvalid <= 1'b1;
                    mem_axi_araddr  <= addr;
                    r_state         <= ENG_AR;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_mailbox_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_mailbox_master
// Description : Writes plaintext, polls status, reads back ciphertext over AXI4-lite.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_mailbox_master
    import axi_mailbox_pkg::*;
#(
    parameter logic [31:0] PT_ADDR     = 32'd1144,
    parameter logic [31:0] CT_ADDR     = 32'd1148,
    parameter logic [31:0] STATUS_ADDR = 32'd1151,
    parameter logic [31:0] ADDR_STRIDE = 32'd1,
    parameter int unsigned POLL_GAP    = 8,
    parameter int unsigned POLL_MAX    = 1024
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [127:0] pt,
    output logic         busy,
    output logic         done,
    output logic         timeout,
    output logic [127:0] ct,
    output logic         mem_axi_awvalid,
    input  logic         mem_axi_awready,
    output logic [31:0]  mem_axi_awaddr,
    output logic [2:0]   mem_axi_awprot,
    output logic         mem_axi_wvalid,
    input  logic         mem_axi_wready,
    output logic [31:0]  mem_axi_wdata,
    output logic [3:0]   mem_axi_wstrb,
    input  logic         mem_axi_bvalid,
    output logic         mem_axi_bready,
    output logic         mem_axi_arvalid,
    input  logic         mem_axi_arready,
    output logic [31:0]  mem_axi_araddr,
    output logic [2:0]   mem_axi_arprot,
    input  logic         mem_axi_rvalid,
    output logic         mem_axi_rready,
    input  logic [31:0]  mem_axi_rdata
);

    mb_state_t    r_state;
    logic [1:0]   r_idx;
    logic [127:0] r_pt;
    logic [31:0]  r_poll_cnt;
    logic [31:0]  r_gap_cnt;

    logic         w_req;
    logic         w_we;
    logic [31:0]  w_addr;
    logic [31:0]  w_wdata;
    logic         w_ack;
    logic [31:0]  w_rdata;
    logic [1:0]   w_idx_inc;
    logic         w_poll_last;
    logic         w_gap_last;

    assign w_idx_inc   = r_idx + 2'd1;
    assign w_poll_last = ((r_poll_cnt + 32'd1) == POLL_MAX);
    assign w_gap_last  = (r_gap_cnt == (POLL_GAP - 32'd1));

    // Next request is issued on the same edge the previous response completes
    always_comb begin
        w_req   = 1'b0;
        w_we    = 1'b0;
        w_addr  = 32'd0;
        w_wdata = 32'd0;
        case (r_state)
            MB_IDLE: begin
                if (start) begin
                    w_req   = 1'b1;
                    w_we    = 1'b1;
                    w_addr  = word_addr(PT_ADDR, 2'd0, ADDR_STRIDE);
                    w_wdata = pt[31:0];
                end
            end
            MB_WR: begin
                if (w_ack) begin
                    w_req = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_addr = STATUS_ADDR;
                    end else begin
                        w_we    = 1'b1;
                        w_addr  = word_addr(PT_ADDR, w_idx_inc, ADDR_STRIDE);
                        w_wdata = r_pt[{w_idx_inc, 5'd0} +: 32];
                    end
                end
            end
            MB_PR: begin
                if (w_ack) begin
                    if (w_rdata[STATUS_DONE_BIT]) begin
                        w_req  = 1'b1;
                        w_addr = word_addr(CT_ADDR, 2'd0, ADDR_STRIDE);
                    end else if (!w_poll_last && (POLL_GAP == 0)) begin
                        w_req  = 1'b1;
                        w_addr = STATUS_ADDR;
                    end
                end
            end
            MB_PG: begin
                if (w_gap_last) begin
                    w_req  = 1'b1;
                    w_addr = STATUS_ADDR;
                end
            end
            MB_RA: begin
                if (w_ack && (r_idx != LAST_IDX)) begin
                    w_req  = 1'b1;
                    w_addr = word_addr(CT_ADDR, w_idx_inc, ADDR_STRIDE);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= MB_IDLE;
            r_idx      <= 2'd0;
            r_pt       <= 128'd0;
            r_poll_cnt <= 32'd0;
            r_gap_cnt  <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            ct         <= 128'd0;
        end else begin
            case (r_state)
                MB_IDLE: begin
                    if (start) begin
                        r_pt       <= pt;
                        busy       <= 1'b1;
                        r_idx      <= 2'd0;
                        r_poll_cnt <= 32'd0;
                        r_state    <= MB_WR;
                    end
                end
                MB_WR: begin
                    if (w_ack) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= 2'd0;
                            r_state <= MB_PR;
                        end else begin
                            r_idx <= w_idx_inc;
                        end
                    end
                end
                MB_PR: begin
                    if (w_ack) begin
                        if (w_rdata[STATUS_DONE_BIT]) begin
                            r_idx   <= 2'd0;
                            r_state <= MB_RA;
                        end else begin
                            r_poll_cnt <= r_poll_cnt + 32'd1;
                            if (w_poll_last) begin
                                timeout <= 1'b1;
                                busy    <= 1'b0;
                                r_state <= MB_TO;
                            end else if (POLL_GAP != 0) begin
                                r_gap_cnt <= 32'd0;
                                r_state   <= MB_PG;
                            end
                        end
                    end
                end
                MB_PG: begin
                    if (w_gap_last) r_state <= MB_PR;
                    else            r_gap_cnt <= r_gap_cnt + 32'd1;
                end
                MB_RA: begin
                    if (w_ack) begin
                        ct[{r_idx, 5'd0} +: 32] <= w_rdata;
                        if (r_idx == LAST_IDX) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= MB_DN;
                        end else begin
                            r_idx <= w_idx_inc;
                        end
                    end
                end
                MB_DN: begin
                    done    <= 1'b0;
                    r_state <= MB_IDLE;
                end
                MB_TO: begin
                    timeout <= 1'b0;
                    r_state <= MB_IDLE;
                end
                default: r_state <= MB_IDLE;
            endcase
        end
    end

    axi_lite_single_master u_engine (
        .clk             (clk),
        .resetn          (resetn),
        .req             (w_req),
        .we              (w_we),
        .addr            (w_addr),
        .wdata           (w_wdata),
        .ack             (w_ack),
        .rdata           (w_rdata),
        .mem_axi_awvalid (mem_axi_awvalid),
        .mem_axi_awready (mem_axi_awready),
        .mem_axi_awaddr  (mem_axi_awaddr),
        .mem_axi_awprot  (mem_axi_awprot),
        .mem_axi_wvalid  (mem_axi_wvalid),
        .mem_axi_wready  (mem_axi_wready),
        .mem_axi_wdata   (mem_axi_wdata),
        .mem_axi_wstrb   (mem_axi_wstrb),
        .mem_axi_bvalid  (mem_axi_bvalid),
        .mem_axi_bready  (mem_axi_bready),
        .mem_axi_arvalid (mem_axi_arvalid),
        .mem_axi_arready (mem_axi_arready),
        .mem_axi_araddr  (mem_axi_araddr),
        .mem_axi_arprot  (mem_axi_arprot),
        .mem_axi_rvalid  (mem_axi_rvalid),
        .mem_axi_rready  (mem_axi_rready),
        .mem_axi_rdata   (mem_axi_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_axi_mailbox_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_mailbox_master
// Description : Directed bench; dut_a uses default polling, dut_b uses POLL_MAX=4, POLL_GAP=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_mailbox_master;

    localparam logic [127:0] PT1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] PT2 = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
    localparam logic [127:0] CT1 = 128'h00000004_00000003_00000002_00000001;
    localparam logic [127:0] CT3 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] PT_ADDRS = {32'd1147, 32'd1146, 32'd1145, 32'd1144};

    logic clk, resetn, sel, clr, start_a, start_b;
    logic [127:0] pt;

    logic a_busy, a_done, a_timeout, a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready;
    logic b_busy, b_done, b_timeout, b_awvalid, b_wvalid, b_bready, b_arvalid, b_rready;
    logic [127:0] a_ct, b_ct;
    logic [31:0] a_awaddr, a_wdata, a_araddr, b_awaddr, b_wdata, b_araddr;
    logic [2:0] a_awprot, a_arprot, b_awprot, b_arprot;
    logic [3:0] a_wstrb, b_wstrb;

    logic m_busy, m_done, m_timeout, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [127:0] m_ct;
    logic [31:0] m_awaddr, m_wdata, m_araddr;
    logic [2:0] m_awprot, m_arprot;
    logic [3:0] m_wstrb;

    logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [31:0] s_rdata;

    int n_cmp, n_bad, cyc;
    int aw_delay, w_delay, status_zeros;
    logic [31:0] ct_data [4];

    int aw_wait, w_wait, wr_cnt, aw_hs_cnt, w_hs_cnt, ar_cnt, status_cnt;
    int last_status, min_gap, stable_err, proto_err;
    logic got_aw, got_w, ct_phase, aw_hold, w_hold;
    logic [31:0] lat_addr, lat_data, aw_prev, w_prev;
    logic [31:0] wr_addr [8];
    logic [31:0] wr_data [8];
    logic t_aw, t_w;
    logic [31:0] t_addr, t_data, t_idx;
    int t_start, t_end;

    assign m_busy    = sel ? b_busy    : a_busy;
    assign m_done    = sel ? b_done    : a_done;
    assign m_timeout = sel ? b_timeout : a_timeout;
    assign m_ct      = sel ? b_ct      : a_ct;
    assign m_awvalid = sel ? b_awvalid : a_awvalid;
    assign m_awaddr  = sel ? b_awaddr  : a_awaddr;
    assign m_awprot  = sel ? b_awprot  : a_awprot;
    assign m_wvalid  = sel ? b_wvalid  : a_wvalid;
    assign m_wdata   = sel ? b_wdata   : a_wdata;
    assign m_wstrb   = sel ? b_wstrb   : a_wstrb;
    assign m_bready  = sel ? b_bready  : a_bready;
    assign m_arvalid = sel ? b_arvalid : a_arvalid;
    assign m_araddr  = sel ? b_araddr  : a_araddr;
    assign m_arprot  = sel ? b_arprot  : a_arprot;
    assign m_rready  = sel ? b_rready  : a_rready;

    assign s_awready = m_awvalid && (aw_wait >= aw_delay);
    assign s_wready  = m_wvalid && (w_wait >= w_delay);
    assign s_arready = m_arvalid;

    axi_mailbox_master dut_a (
        .clk(clk), .resetn(resetn), .start(start_a), .pt(pt),
        .busy(a_busy), .done(a_done), .timeout(a_timeout), .ct(a_ct),
        .mem_axi_awvalid(a_awvalid), .mem_axi_awready(!sel && s_awready),
        .mem_axi_awaddr(a_awaddr), .mem_axi_awprot(a_awprot),
        .mem_axi_wvalid(a_wvalid), .mem_axi_wready(!sel && s_wready),
        .mem_axi_wdata(a_wdata), .mem_axi_wstrb(a_wstrb),
        .mem_axi_bvalid(!sel && s_bvalid), .mem_axi_bready(a_bready),
        .mem_axi_arvalid(a_arvalid), .mem_axi_arready(!sel && s_arready),
        .mem_axi_araddr(a_araddr), .mem_axi_arprot(a_arprot),
        .mem_axi_rvalid(!sel && s_rvalid), .mem_axi_rready(a_rready),
        .mem_axi_rdata(s_rdata)
    );

    axi_mailbox_master #(.POLL_MAX(4), .POLL_GAP(0)) dut_b (
        .clk(clk), .resetn(resetn), .start(start_b), .pt(pt),
        .busy(b_busy), .done(b_done), .timeout(b_timeout), .ct(b_ct),
        .mem_axi_awvalid(b_awvalid), .mem_axi_awready(sel && s_awready),
        .mem_axi_awaddr(b_awaddr), .mem_axi_awprot(b_awprot),
        .mem_axi_wvalid(b_wvalid), .mem_axi_wready(sel && s_wready),
        .mem_axi_wdata(b_wdata), .mem_axi_wstrb(b_wstrb),
        .mem_axi_bvalid(sel && s_bvalid), .mem_axi_bready(b_bready),
        .mem_axi_arvalid(b_arvalid), .mem_axi_arready(sel && s_arready),
        .mem_axi_araddr(b_araddr), .mem_axi_arprot(b_arprot),
        .mem_axi_rvalid(sel && s_rvalid), .mem_axi_rready(b_rready),
        .mem_axi_rdata(s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reactive slave with configurable ready delays, status sequence and CT contents
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!resetn || clr) begin
            got_aw <= 1'b0; got_w <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0;
            aw_wait <= 0; w_wait <= 0; ct_phase <= 1'b0; aw_hold <= 1'b0; w_hold <= 1'b0;
            if (clr) begin
                wr_cnt <= 0; aw_hs_cnt <= 0; w_hs_cnt <= 0; ar_cnt <= 0; status_cnt <= 0;
                min_gap <= 999999; stable_err <= 0; proto_err <= 0; last_status <= 0;
            end
        end else begin
            if (aw_hold && !(m_awvalid && m_awaddr == aw_prev)) stable_err <= stable_err + 1;
            if (w_hold && !(m_wvalid && m_wdata == w_prev)) stable_err <= stable_err + 1;
            aw_hold <= m_awvalid && !s_awready;
            aw_prev <= m_awaddr;
            w_hold  <= m_wvalid && !s_wready;
            w_prev  <= m_wdata;
            if (m_arvalid && (m_awvalid || m_wvalid || got_aw || got_w || s_bvalid))
                proto_err <= proto_err + 1;

            if (m_awvalid && s_awready) begin
                aw_hs_cnt <= aw_hs_cnt + 1; lat_addr <= m_awaddr; aw_wait <= 0;
            end else if (m_awvalid) aw_wait <= aw_wait + 1;
            if (m_wvalid && s_wready) begin
                w_hs_cnt <= w_hs_cnt + 1; lat_data <= m_wdata; w_wait <= 0;
            end else if (m_wvalid) w_wait <= w_wait + 1;

            t_aw   = got_aw || (m_awvalid && s_awready);
            t_w    = got_w || (m_wvalid && s_wready);
            t_addr = (m_awvalid && s_awready) ? m_awaddr : lat_addr;
            t_data = (m_wvalid && s_wready) ? m_wdata : lat_data;
            if (t_aw && t_w) begin
                wr_addr[wr_cnt[2:0]] <= t_addr;
                wr_data[wr_cnt[2:0]] <= t_data;
                wr_cnt <= wr_cnt + 1;
                got_aw <= 1'b0; got_w <= 1'b0; s_bvalid <= 1'b1;
            end else begin
                if (m_awvalid && s_awready) got_aw <= 1'b1;
                if (m_wvalid && s_wready)   got_w  <= 1'b1;
            end
            if (s_bvalid && m_bready) s_bvalid <= 1'b0;

            // STATUS_ADDR aliases CT word 3, so status vs CT is told apart by phase
            if (m_arvalid && s_arready) begin
                ar_cnt <= ar_cnt + 1;
                s_rvalid <= 1'b1;
                if (!ct_phase && m_araddr == 32'd1151) begin
                    status_cnt <= status_cnt + 1;
                    if (status_cnt > 0 && (cyc - last_status) < min_gap) min_gap <= cyc - last_status;
                    last_status <= cyc;
                    if (status_cnt >= status_zeros) begin
                        s_rdata <= 32'h0000_0001; ct_phase <= 1'b1;
                    end else s_rdata <= 32'hFFFF_FFFE;
                end else begin
                    t_idx = m_araddr - 32'd1148;
                    s_rdata <= ct_data[t_idx[1:0]];
                end
            end
            if (s_rvalid && m_rready) s_rvalid <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_test();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic run_start(input logic [127:0] p);
        pt = p;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        t_start = cyc;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(m_done || m_timeout) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        t_end = cyc;
        check("end_seen", m_done || m_timeout, 1'b1);
    endtask

    task automatic set_ct_plain();
        ct_data[0] = 32'h1; ct_data[1] = 32'h2; ct_data[2] = 32'h3; ct_data[3] = 32'h4;
    endtask

    initial begin
        int n;
        cyc = 0; n_cmp = 0; n_bad = 0;
        resetn = 1'b0; sel = 1'b0; clr = 1'b0; start_a = 1'b0; start_b = 1'b0; pt = '0;
        aw_delay = 0; w_delay = 0; status_zeros = 0;
        set_ct_plain();
        new_test();
        repeat (2) @(negedge clk);
        check("rst_busy_done_to", {m_busy, m_done, m_timeout}, 3'b000);
        check("rst_valids_readies", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 5'b0);
        check("rst_ct", m_ct, 128'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Zero-wait slave, first poll succeeds
        new_test();
        run_start(PT1);
        check("busy_after_start", m_busy, 1'b1);
        wait_end();
        check("t1_latency", t_end - t_start, 18);
        check("t1_done", m_done, 1'b1);
        check("t1_busy_at_done", m_busy, 1'b0);
        check("t1_ct", m_ct, CT1);
        check("t1_wr_cnt", wr_cnt, 4);
        check("t1_wr_addr", {wr_addr[3], wr_addr[2], wr_addr[1], wr_addr[0]}, PT_ADDRS);
        check("t1_wr_data", {wr_data[3], wr_data[2], wr_data[1], wr_data[0]}, PT1);
        check("t1_status_reads", status_cnt, 1);
        check("t1_strb_prot", {m_wstrb, m_awprot, m_arprot}, {4'hF, 3'b000, 3'b000});
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("start_in_done_ignored", {m_busy, m_done, m_awvalid}, 3'b000);

        // awready delayed, then wready delayed
        new_test();
        aw_delay = 3; w_delay = 0;
        run_start(PT1);
        wait_end();
        check("t2a_hs_counts", {aw_hs_cnt[7:0], w_hs_cnt[7:0], wr_cnt[7:0]}, 24'h040404);
        check("t2a_wr_data", {wr_data[3], wr_data[2], wr_data[1], wr_data[0]}, PT1);
        check("t2a_stable", stable_err, 0);
        new_test();
        aw_delay = 0; w_delay = 3;
        run_start(PT2);
        wait_end();
        check("t2b_hs_counts", {aw_hs_cnt[7:0], w_hs_cnt[7:0], wr_cnt[7:0]}, 24'h040404);
        check("t2b_wr_addr", {wr_addr[3], wr_addr[2], wr_addr[1], wr_addr[0]}, PT_ADDRS);
        check("t2b_wr_data", {wr_data[3], wr_data[2], wr_data[1], wr_data[0]}, PT2);
        check("t2b_stable_proto", {stable_err[7:0], proto_err[7:0]}, 16'h0);
        w_delay = 0;

        // Five not-done polls then done, POLL_GAP=8
        new_test();
        status_zeros = 5;
        ct_data[0] = 32'h11111111; ct_data[1] = 32'h22222222;
        ct_data[2] = 32'h33333333; ct_data[3] = 32'h44444444;
        run_start(PT1);
        wait_end();
        check("t3_done", m_done, 1'b1);
        check("t3_status_reads", status_cnt, 6);
        check("t3_total_reads", ar_cnt, 10);
        check("t3_poll_spacing", min_gap >= 10, 1'b1);
        check("t3_ct", m_ct, CT3);
        check("t3_proto", proto_err, 0);

        // dut_b: a clean run, then a timeout run with POLL_MAX=4
        sel = 1'b1;
        set_ct_plain();
        new_test();
        status_zeros = 0;
        run_start(PT2);
        wait_end();
        check("t4_first_ct", m_ct, CT1);
        new_test();
        status_zeros = 1000;
        run_start(PT1);
        wait_end();
        check("t4_timeout", {m_timeout, m_done, m_busy}, 3'b100);
        check("t4_status_reads", status_cnt, 4);
        check("t4_ct_unchanged", m_ct, CT1);
        @(negedge clk);
        check("t4_timeout_pulse", m_timeout, 1'b0);
        sel = 1'b0;
        status_zeros = 0;

        // Second start during WB is ignored
        new_test();
        run_start(PT1);
        n = 0;
        while (!m_bready && n < 100) begin @(negedge clk); n++; end
        check("t5_wb_reached", m_bready, 1'b1);
        pt = PT2; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_end();
        check("t5_wr_cnt", wr_cnt, 4);
        check("t5_wr_data", {wr_data[3], wr_data[2], wr_data[1], wr_data[0]}, PT1);

        // Reset while reading CT word 2
        new_test();
        run_start(PT2);
        n = 0;
        while (!(m_rready && ct_phase && m_araddr == 32'd1150) && n < 200) begin @(negedge clk); n++; end
        check("t6_rd2_reached", m_rready && (m_araddr == 32'd1150), 1'b1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("t6_valids_cleared", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 5'b0);
        check("t6_busy_done", {m_busy, m_done}, 2'b00);
        check("t6_ct_cleared", m_ct, 128'd0);
        repeat (3) @(negedge clk);
        check("t6_no_completion", m_done, 1'b0);
        new_test();
        run_start(PT1);
        wait_end();
        check("t6_rerun_latency", t_end - t_start, 18);
        check("t6_rerun_ct", m_ct, CT1);
        check("t6_rerun_wr_data", {wr_data[3], wr_data[2], wr_data[1], wr_data[0]}, PT1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_mailbox_master.md
Name: axi_mailbox_master

Overview:
- AXI4-lite initiator that drives the plaintext/ciphertext mailbox protocol from the host side.
- On a start pulse it writes the 128-bit plaintext as four 32-bit words, then polls a status word until the done bit is set.
- It then reads back four ciphertext words and presents them as a 128-bit result.
- Used as the bench-side and host-side counterpart of the mailbox responder; it also bridges CW305 USB registers to any mem_axi slave.

Parameters:
- PT_ADDR, 32'd1144: address of plaintext word 0.
- CT_ADDR, 32'd1148: address of ciphertext word 0.
- STATUS_ADDR, 32'd1151: address polled for completion; bit 0 = done.
- ADDR_STRIDE, 1: address increment between consecutive words (1 = word-indexed, 4 = byte-indexed).
- POLL_GAP, 8: idle cycles between successive status reads.
- POLL_MAX, 1024: status reads before declaring timeout.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- start  in  1  single-cycle request; sampled only when busy=0
- pt  in  128  plaintext; captured on accepted start; word i = pt[32i+31:32i]
- busy  out  1  high from the cycle after accepted start until done/timeout
- done  out  1  one-cycle pulse when ct is valid
- timeout  out  1  one-cycle pulse when POLL_MAX is exceeded
- ct  out  128  ciphertext; word i at CT_ADDR+i*ADDR_STRIDE
- mem_axi_awvalid out 1, mem_axi_awready in 1, mem_axi_awaddr out 32, mem_axi_awprot out 3 (always 3'b000)
- mem_axi_wvalid out 1, mem_axi_wready in 1, mem_axi_wdata out 32, mem_axi_wstrb out 4 (always 4'hF)
- mem_axi_bvalid in 1, mem_axi_bready out 1
- mem_axi_arvalid out 1, mem_axi_arready in 1, mem_axi_araddr out 32, mem_axi_arprot out 3 (always 3'b000)
- mem_axi_rvalid in 1, mem_axi_rready out 1, mem_axi_rdata in 32

Behaviour:
- Reset (resetn=0 at a clk edge) forces:
  - state IDLE;
  - all valid, ready, busy, done and timeout outputs to 0;
  - ct to 0;
  - word and poll counters to 0.
- Reset mid-transaction drops valids immediately and abandons the transfer; no completion is reported.
- States and transitions:
  - IDLE: on start, capture pt, set busy, idx=0 -> WR.
  - WR: assert awvalid with awaddr=PT_ADDR+idx*ADDR_STRIDE, and wvalid with wdata=pt word idx.
    - Each valid drops independently on its own handshake; the two may complete in either order or the same cycle.
    - When both have completed -> WB.
  - WB: bready=1. On bvalid, BRESP is ignored; if idx=3 -> PR with idx=0, else idx+1 -> WR.
  - PR: arvalid, araddr=STATUS_ADDR; on arready -> PRD.
  - PRD: rready=1. On rvalid:
    - rdata[0]=1 -> RA.
    - Else increment poll count; if count reaches POLL_MAX -> TO, else -> PG.
  - PG: count POLL_GAP cycles -> PR. POLL_GAP=0 means PR is re-entered on the next cycle.
  - RA: arvalid, araddr=CT_ADDR+idx*ADDR_STRIDE; on arready -> RD.
  - RD: rready=1. On rvalid, load ct word idx from rdata; if idx=3 -> DN, else idx+1 -> RA.
  - DN: done=1 for one cycle, busy=0 -> IDLE.
  - TO: timeout=1 for one cycle, busy=0, ct unchanged -> IDLE.
- Handshake rules:
  - A valid, once asserted, is held until its ready is seen.
  - Address, data and strobe stay stable while valid is high.
  - Never more than one outstanding transaction.
  - arvalid is never asserted while a write is outstanding.
- Latency:
  - A zero-wait slave (ready in the cycle valid rises, response one cycle after the handshake) gives 2 cycles per transaction.
  - Under those conditions, the first poll succeeding and POLL_GAP=0, done rises 18 cycles after the start edge.
- Other rules:
  - start while busy is ignored; pt is not recaptured.
  - start coincident with a done cycle is ignored.
  - Address arithmetic is 32-bit and wraps modulo 2^32.
  - ct updates only in RD; it holds its last value otherwise.

Decomposition:
- Package axi_mailbox_pkg:
  - state enum;
  - constant NWORDS=4;
  - STATUS_DONE_BIT=0;
  - prot/strobe constants.
- One natural sub-module, axi_lite_single_master: a generic single-beat read/write engine with req/addr/wdata/we in and ack/rdata out.
- The mailbox FSM sequences that engine.

Test Plan:
- Zero-wait slave, first status read returns 1, pt=128'h00112233_44556677_8899AABB_CCDDEEFF:
  - writes of 32'hCCDDEEFF @1144, 32'h8899AABB @1145, 32'h44556677 @1146, 32'h00112233 @1147;
  - reads of CT words 32'h1,2,3,4 give ct=128'h4_3_2_1 (word-packed);
  - done pulses 18 cycles after start.
- Slave delays awready 3 cycles but takes wready immediately (and vice versa):
  - each write completes exactly once;
  - awaddr and wdata stay stable while their valids are high.
- Status returns 0 five times, then 1, POLL_GAP=8:
  - six ARs to 1151 spaced ≥8 idle cycles apart, then CT reads, then done.
- Status always 0, POLL_MAX=4:
  - exactly 4 status reads, then a timeout pulse with busy=0 and ct unchanged.
- start pulsed again during WB with a different pt:
  - ignored; written data matches the first pt.
- resetn=0 for 1 cycle during RD idx=2:
  - next cycle all valids=0, busy=0, ct=0;
  - a later start runs a full clean sequence.
